vid_mode_ctrl: RTL and testbench

VID_MODE_CTRL -- requirements
Module: vid_mode_ctrl

---
 rtl/vid_pkg.sv | 38 +++
 rtl/vid_mode_check.sv | 12 +
 rtl/vid_mode_ctrl.sv | 133 +++++++++++++
 tb/tb_vid_mode_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types and constants for the video mode controller: packed mode word,
// field offsets, 640x480 default timings and FSM state encoding.
package vid_pkg;

  localparam int unsigned FIELD_W    = 12;
  localparam int unsigned MODE_W     = 4 * FIELD_W;
  localparam int unsigned OFF_WIDTH  = 3 * FIELD_W;
  localparam int unsigned OFF_PORCH  = 2 * FIELD_W;
  localparam int unsigned OFF_SYNCH  = 1 * FIELD_W;
  localparam int unsigned OFF_RAW    = 0;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned MIN_ACTIVE = 16;

  // {width, porch, synch, raw}; for the vertical mode "width" is the height
  typedef struct packed {
    logic [FIELD_W-1:0] width;
    logic [FIELD_W-1:0] porch;
    logic [FIELD_W-1:0] synch;
    logic [FIELD_W-1:0] raw;
  } mode_t;

  localparam logic [MODE_W-1:0] DEF_HMODE = {12'd640, 12'd656, 12'd752, 12'd800};
  localparam logic [MODE_W-1:0] DEF_VMODE = {12'd480, 12'd490, 12'd492, 12'd525};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    HOLD       = 2'd2,
    SETTLE     = 2'd3
  } state_t;

  // Fields must be strictly increasing and the active region larger than MIN_ACTIVE
  function automatic logic mode_ok(mode_t m);
    return (m.width > FIELD_W'(MIN_ACTIVE)) && (m.porch > m.width) &&
           (m.synch > m.porch) && (m.raw > m.synch);
  endfunction

endpackage

// File: rtl/vid_mode_check.sv
// Combinational legality check of a requested horizontal/vertical mode pair.
module vid_mode_check
  import vid_pkg::*;
(
  input  logic [MODE_W-1:0] i_hmode,
  input  logic [MODE_W-1:0] i_vmode,
  output logic              o_legal_c
);

  assign o_legal_c = mode_ok(mode_t'(i_hmode)) && mode_ok(mode_t'(i_vmode));

endmodule

// File: rtl/vid_mode_ctrl.sv
// Video mode switch controller: applies new timings only while the timing
// generator is held in reset. Optional request check under VID_MODE_CHECK_EN.
module vid_mode_ctrl #(
  parameter int unsigned           RESET_CYCLES = 4,
  parameter logic [vid_pkg::MODE_W-1:0] DEF_HMODE = vid_pkg::DEF_HMODE,
  parameter logic [vid_pkg::MODE_W-1:0] DEF_VMODE = vid_pkg::DEF_VMODE
) (
  input  logic                          i_pixclk,
  input  logic                          i_reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [vid_pkg::MODE_W-1:0]    i_req_hmode,
  input  logic [vid_pkg::MODE_W-1:0]    i_req_vmode,
  input  logic                          i_newframe,
  output logic [vid_pkg::FIELD_W-1:0]   o_hm_width,
  output logic [vid_pkg::FIELD_W-1:0]   o_hm_porch,
  output logic [vid_pkg::FIELD_W-1:0]   o_hm_synch,
  output logic [vid_pkg::FIELD_W-1:0]   o_hm_raw,
  output logic [vid_pkg::FIELD_W-1:0]   o_vm_height,
  output logic [vid_pkg::FIELD_W-1:0]   o_vm_porch,
  output logic [vid_pkg::FIELD_W-1:0]   o_vm_synch,
  output logic [vid_pkg::FIELD_W-1:0]   o_vm_raw,
  output logic                          o_vid_reset,
  output logic                          o_busy,
  output logic                          o_err
);
  import vid_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mode_t              pend_h_q, pend_h_d, pend_v_q, pend_v_d;
  mode_t              hmode_q, hmode_d, vmode_q, vmode_d;
  logic               vid_reset_q, vid_reset_d;
  logic               err_q, err_d;
  logic               ready_q, busy_q;
  logic               req_legal;

`ifdef VID_MODE_CHECK_EN
  vid_mode_check u_check (
    .i_hmode   (i_req_hmode),
    .i_vmode   (i_req_vmode),
    .o_legal_c (req_legal)
  );
`else
  assign req_legal = 1'b1;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_h_d    = pend_h_q;
    pend_v_d    = pend_v_q;
    hmode_d     = hmode_q;
    vmode_d     = vmode_q;
    vid_reset_d = vid_reset_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid && ready_q) begin
          if (req_legal) begin
            pend_h_d = mode_t'(i_req_hmode);
            pend_v_d = mode_t'(i_req_vmode);
            state_d  = WAIT_FRAME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_FRAME: begin
        if (i_newframe) begin
          state_d     = HOLD;
          hmode_d     = pend_h_q;
          vmode_d     = pend_v_q;
          vid_reset_d = 1'b1;
          cnt_d       = CNT_W'(RESET_CYCLES);
        end
      end
      HOLD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = SETTLE;
          vid_reset_d = 1'b0;
        end
      end
      SETTLE: begin
        if (i_newframe) state_d = IDLE;
      end
      default: state_d = HOLD;
    endcase
  end

  // State and registered outputs; reset restarts the HOLD/SETTLE sequence
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q     <= HOLD;
      cnt_q       <= CNT_W'(RESET_CYCLES);
      pend_h_q    <= mode_t'(DEF_HMODE);
      pend_v_q    <= mode_t'(DEF_VMODE);
      hmode_q     <= mode_t'(DEF_HMODE);
      vmode_q     <= mode_t'(DEF_VMODE);
      vid_reset_q <= 1'b1;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_h_q    <= pend_h_d;
      pend_v_q    <= pend_v_d;
      hmode_q     <= hmode_d;
      vmode_q     <= vmode_d;
      vid_reset_q <= vid_reset_d;
      err_q       <= err_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign o_req_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_vid_reset = vid_reset_q;
  assign o_hm_width  = hmode_q.width;
  assign o_hm_porch  = hmode_q.porch;
  assign o_hm_synch  = hmode_q.synch;
  assign o_hm_raw    = hmode_q.raw;
  assign o_vm_height = vmode_q.width;
  assign o_vm_porch  = vmode_q.porch;
  assign o_vm_synch  = vmode_q.synch;
  assign o_vm_raw    = vmode_q.raw;

endmodule

// File: tb/tb_vid_mode_ctrl.sv
// Directed self-checking bench for vid_mode_ctrl: request table plus
// hand-written reset, strobe-coincidence and back-to-back sequences.
module tb_vid_mode_ctrl;

  localparam int unsigned RC = 4;
  localparam logic [47:0] DEF_H = {12'd640, 12'd656, 12'd752, 12'd800};
  localparam logic [47:0] DEF_V = {12'd480, 12'd490, 12'd492, 12'd525};

  logic        i_pixclk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_newframe = 1'b0;
  logic [47:0] i_req_hmode = '0;
  logic [47:0] i_req_vmode = '0;
  logic        o_req_ready, o_vid_reset, o_busy, o_err;
  logic [11:0] o_hm_width, o_hm_porch, o_hm_synch, o_hm_raw;
  logic [11:0] o_vm_height, o_vm_porch, o_vm_synch, o_vm_raw;

  int n_assert = 0;
  int n_fail = 0;
  logic [47:0] cur_h, cur_v;
  bit chk_en;

  typedef struct {
    logic [47:0] h;
    logic [47:0] v;
    bit          legal;
  } vec_t;
  vec_t tbl [5];

  wire [47:0] hm_o = {o_hm_width, o_hm_porch, o_hm_synch, o_hm_raw};
  wire [47:0] vm_o = {o_vm_height, o_vm_porch, o_vm_synch, o_vm_raw};

  vid_mode_ctrl #(.RESET_CYCLES(RC)) dut (
    .i_pixclk    (i_pixclk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_hmode (i_req_hmode),
    .i_req_vmode (i_req_vmode),
    .i_newframe  (i_newframe),
    .o_hm_width  (o_hm_width),
    .o_hm_porch  (o_hm_porch),
    .o_hm_synch  (o_hm_synch),
    .o_hm_raw    (o_hm_raw),
    .o_vm_height (o_vm_height),
    .o_vm_porch  (o_vm_porch),
    .o_vm_synch  (o_vm_synch),
    .o_vm_raw    (o_vm_raw),
    .o_vid_reset (o_vid_reset),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_pixclk = ~i_pixclk;

  function automatic logic [47:0] mk(int w, int p, int s, int r);
    return {12'(w), 12'(p), 12'(s), 12'(r)};
  endfunction

  task automatic tick();
    @(negedge i_pixclk);
  endtask

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_frame();
    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
  endtask

  // Counts consecutive samples with o_vid_reset high, starting now
  task automatic count_vres(output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (o_vid_reset !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (o_req_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk1("ready_wait", o_req_ready, 1'b1);
  endtask

  // Reset for 3 cycles, then follow the HOLD/SETTLE recovery into IDLE
  task automatic reset_seq();
    int n;
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    i_newframe = 1'b0;
    tick();
    chk("rst_hmode", hm_o, DEF_H);
    chk("rst_vmode", vm_o, DEF_V);
    chk1("rst_vid_reset", o_vid_reset, 1'b1);
    chk1("rst_busy", o_busy, 1'b1);
    chk1("rst_ready", o_req_ready, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    tick();
    tick();
    i_reset = 1'b0;
    count_vres(n);
    chk_int("rst_hold_len", n, RC);
    chk1("rst_settle_busy", o_busy, 1'b1);
    tick();
    tick();
    chk1("rst_settle_ready", o_req_ready, 1'b0);
    pulse_frame();
    chk1("rst_ready_after_frame", o_req_ready, 1'b1);
    chk1("rst_idle_busy", o_busy, 1'b0);
    chk("rst_idle_hmode", hm_o, DEF_H);
    cur_h = DEF_H;
    cur_v = DEF_V;
  endtask

  // From WAIT_FRAME: strobe, check HOLD contents and length, SETTLE, back to IDLE
  task automatic switch_tail(logic [47:0] h, logic [47:0] v, bit frame_in_hold);
    int n, exp_n;
    pulse_frame();
    chk("hold_hmode", hm_o, h);
    chk("hold_vmode", vm_o, v);
    chk1("hold_vid_reset", o_vid_reset, 1'b1);
    exp_n = RC;
    if (frame_in_hold) begin
      pulse_frame();
      exp_n = RC - 1;
    end
    count_vres(n);
    chk_int("hold_len", n, exp_n);
    chk1("settle_busy", o_busy, 1'b1);
    chk1("settle_ready", o_req_ready, 1'b0);
    tick();
    chk1("settle_busy_stays", o_busy, 1'b1);
    pulse_frame();
    chk1("idle_ready", o_req_ready, 1'b1);
    chk1("idle_busy", o_busy, 1'b0);
    chk("idle_hmode", hm_o, h);
    cur_h = h;
    cur_v = v;
  endtask

  task automatic do_req(logic [47:0] h, logic [47:0] v, bit applied);
    wait_ready();
    i_req_hmode = h;
    i_req_vmode = v;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    if (applied) begin
      chk1("req_busy", o_busy, 1'b1);
      chk1("req_err", o_err, 1'b0);
      chk("req_hmode_unchanged", hm_o, cur_h);
      switch_tail(h, v, 1'b0);
    end else begin
      chk1("bad_err_pulse", o_err, 1'b1);
      chk1("bad_busy", o_busy, 1'b0);
      chk1("bad_ready", o_req_ready, 1'b1);
      chk("bad_hmode", hm_o, cur_h);
      tick();
      chk1("bad_err_clear", o_err, 1'b0);
      chk("bad_vmode", vm_o, cur_v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit stable;
    int n;
    chk_en = 1'b0;
`ifdef VID_MODE_CHECK_EN
    chk_en = 1'b1;
`endif
    tbl[0] = '{mk(800, 840, 968, 1056),   mk(600, 601, 605, 628), 1'b1};
    tbl[1] = '{mk(1024, 1048, 1184, 1344), mk(768, 771, 777, 806), 1'b1};
    tbl[2] = '{mk(640, 656, 752, 800),    mk(480, 490, 492, 525), 1'b1};
    tbl[3] = '{mk(700, 656, 752, 800),    mk(480, 490, 492, 525), 1'b0};
    tbl[4] = '{mk(640, 656, 752, 800),    mk(16, 490, 492, 525),  1'b0};

    reset_seq();

    // Strobe in IDLE has no effect
    pulse_frame();
    chk1("idle_frame_busy", o_busy, 1'b0);
    chk("idle_frame_hmode", hm_o, cur_h);

    // Request, long wait before strobe; strobe during HOLD is dropped
    wait_ready();
    i_req_hmode = tbl[0].h;
    i_req_vmode = tbl[0].v;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    chk1("acc_busy", o_busy, 1'b1);
    chk1("acc_ready", o_req_ready, 1'b0);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (hm_o !== cur_h || vm_o !== cur_v || o_vid_reset !== 1'b0) stable = 1'b0;
    end
    chk1("wait_frame_stable", stable, 1'b1);
    switch_tail(tbl[0].h, tbl[0].v, 1'b1);
    chk("raw_1056", 48'(o_hm_raw), 48'd1056);

    // Strobe coinciding with accept is ignored
    wait_ready();
    i_req_hmode = tbl[1].h;
    i_req_vmode = tbl[1].v;
    i_req_valid = 1'b1;
    i_newframe = 1'b1;
    tick();
    i_req_valid = 1'b0;
    i_newframe = 1'b0;
    chk1("coinc_no_hold", o_vid_reset, 1'b0);
    chk1("coinc_busy", o_busy, 1'b1);
    tick();
    tick();
    tick();
    chk("coinc_hmode", hm_o, cur_h);
    chk1("coinc_still_no_hold", o_vid_reset, 1'b0);
    switch_tail(tbl[1].h, tbl[1].v, 1'b0);

    // Table of single requests, legal and illegal
    for (int i = 0; i < 5; i++) begin
      do_req(tbl[i].h, tbl[i].v, tbl[i].legal | ~chk_en);
    end

    // Valid held high across three back-to-back mode switches
    i_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_req_hmode = tbl[i].h;
      i_req_vmode = tbl[i].v;
      wait_ready();
      tick();
      chk1("b2b_accept", o_busy, 1'b1);
      if (i < 2) begin
        i_req_hmode = tbl[i+1].h;
        i_req_vmode = tbl[i+1].v;
      end else begin
        i_req_valid = 1'b0;
      end
      switch_tail(tbl[i].h, tbl[i].v, 1'b0);
    end

    // Reset in WAIT_FRAME discards the pending request
    wait_ready();
    i_req_hmode = tbl[0].h;
    i_req_vmode = tbl[0].v;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    chk1("wf_busy", o_busy, 1'b1);
    reset_seq();
    pulse_frame();
    chk1("wf_no_pending_busy", o_busy, 1'b0);
    chk("wf_no_pending_hmode", hm_o, DEF_H);

    // Reset in SETTLE restores defaults on the next cycle
    wait_ready();
    i_req_hmode = tbl[1].h;
    i_req_vmode = tbl[1].v;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
    pulse_frame();
    count_vres(n);
    chk_int("st_hold_len", n, RC);
    chk("st_settle_hmode", hm_o, tbl[1].h);
    reset_seq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
